// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through byte FIFO behind the UART receiver,
//               with fill level, threshold interrupt and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              rd_en_i,
    output logic [7:0]        rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o,
    input  logic [ADDR_W:0]   thresh_i,
    input  logic              ovr_clr_i,
    output logic              overrun_o,
    output logic              irq_o
);

    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;

    logic w_in_fire;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign in_ready_o = cfg_en_i & ~rst;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == c_DEPTH);
    assign count_o    = count_q;
    assign overrun_o  = overrun_q;
    assign rd_data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign irq_o      = ((thresh_i != '0) && (count_q >= thresh_i)) || overrun_q;

    assign w_in_fire = in_valid_i & in_ready_o;
    assign w_pop     = rd_en_i & ~empty_o & cfg_en_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign w_push    = w_in_fire & (~full_o | w_pop);
    assign w_drop    = w_in_fire & full_o & ~rd_en_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_CNT_ONE;
        end
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !cfg_en_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: rd_data_o is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       cfg_en_i;
    logic [7:0] in_data_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       rd_en_i;
    logic [7:0] rd_data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic [4:0] thresh_i;
    logic       ovr_clr_i;
    logic       overrun_o;
    logic       irq_o;

    int total;
    int bad;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en_i   (cfg_en_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .rd_en_i    (rd_en_i),
        .rd_data_o  (rd_data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .thresh_i   (thresh_i),
        .ovr_clr_i  (ovr_clr_i),
        .overrun_o  (overrun_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_data_i  = d;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        cfg_en_i   = 1'b1;
        in_data_i  = 8'h00;
        in_valid_i = 1'b0;
        rd_en_i    = 1'b0;
        thresh_i   = 5'd0;
        ovr_clr_i  = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_count", {27'd0, count_o}, 32'd0);
        chk("rst_empty", {31'd0, empty_o}, 32'd1);
        chk("rst_full", {31'd0, full_o}, 32'd0);
        chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_data", {24'd0, rd_data_o}, 32'd0);
        chk("ready_en", {31'd0, in_ready_o}, 32'd1);

        // single byte
        push(8'hA5);
        chk("a5_empty", {31'd0, empty_o}, 32'd0);
        chk("a5_count", {27'd0, count_o}, 32'd1);
        chk("a5_data", {24'd0, rd_data_o}, 32'hA5);
        pop();
        chk("a5_pop_empty", {31'd0, empty_o}, 32'd1);
        chk("a5_pop_data", {24'd0, rd_data_o}, 32'd0);

        // pop on empty ignored
        pop();
        chk("pop_empty_cnt", {27'd0, count_o}, 32'd0);

        // fill and drain with wrap
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", {31'd0, full_o}, 32'd1);
        chk("fill_count", {27'd0, count_o}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), {24'd0, rd_data_o}, 32'(i));
            pop();
        end
        chk("drain_empty", {31'd0, empty_o}, 32'd1);
        chk("drain_count", {27'd0, count_o}, 32'd0);

        // overrun
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        push(8'h77);
        chk("ovr_set", {31'd0, overrun_o}, 32'd1);
        chk("ovr_irq", {31'd0, irq_o}, 32'd1);
        chk("ovr_count", {27'd0, count_o}, 32'd16);
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
        chk("ovr_clr", {31'd0, overrun_o}, 32'd0);
        chk("ovr_clr_irq", {31'd0, irq_o}, 32'd0);

        // push+pop while full
        chk("pp_head", {24'd0, rd_data_o}, 32'h10);
        in_data_i  = 8'h55;
        in_valid_i = 1'b1;
        rd_en_i    = 1'b1;
        tick();
        in_valid_i = 1'b0;
        rd_en_i    = 1'b0;
        chk("pp_ovr", {31'd0, overrun_o}, 32'd0);
        chk("pp_count", {27'd0, count_o}, 32'd16);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp_drain_%0d", i), {24'd0, rd_data_o}, 32'(8'h10 + i));
            pop();
        end
        chk("pp_last", {24'd0, rd_data_o}, 32'h55);
        pop();
        chk("pp_empty", {31'd0, empty_o}, 32'd1);

        // push+pop when empty: push wins
        in_data_i  = 8'h3C;
        in_valid_i = 1'b1;
        rd_en_i    = 1'b1;
        tick();
        in_valid_i = 1'b0;
        rd_en_i    = 1'b0;
        chk("ppe_count", {27'd0, count_o}, 32'd1);
        chk("ppe_data", {24'd0, rd_data_o}, 32'h3C);
        pop();

        // threshold interrupt
        thresh_i = 5'd4;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("th_3", {31'd0, irq_o}, 32'd0);
        push(8'h04);
        chk("th_4", {31'd0, irq_o}, 32'd1);
        pop();
        chk("th_pop", {31'd0, irq_o}, 32'd0);
        push(8'h05);
        chk("th_again", {31'd0, irq_o}, 32'd1);
        thresh_i = 5'd0;
        #1;
        chk("th_zero", {31'd0, irq_o}, 32'd0);
        thresh_i = 5'd5;
        #1;
        chk("th_5_at4", {31'd0, irq_o}, 32'd0);

        // cfg_en flush with 5 bytes
        push(8'h06);
        chk("pre_flush_cnt", {27'd0, count_o}, 32'd5);
        chk("th_5_at5", {31'd0, irq_o}, 32'd1);
        thresh_i = 5'd0;
        cfg_en_i = 1'b0;
        #1;
        chk("dis_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        cfg_en_i = 1'b1;
        chk("dis_count", {27'd0, count_o}, 32'd0);
        chk("dis_empty", {31'd0, empty_o}, 32'd1);

        // reset mid-push
        push(8'h11);
        push(8'h22);
        push(8'h33);
        rst        = 1'b1;
        in_data_i  = 8'h44;
        in_valid_i = 1'b1;
        #1;
        chk("rstp_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        rst        = 1'b0;
        in_valid_i = 1'b0;
        chk("rstp_count", {27'd0, count_o}, 32'd0);
        chk("rstp_empty", {31'd0, empty_o}, 32'd1);
        chk("rstp_data", {24'd0, rd_data_o}, 32'd0);

        // pointers restart at 0 after reset
        push(8'h99);
        chk("post_rst_data", {24'd0, rd_data_o}, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
